// File: rtl/demux_pkg.sv
// Shared lane definitions for the 1-to-4 stream distributor.
package demux_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] lane_t;

  localparam lane_t LANE_A = 2'd0;
  localparam lane_t LANE_B = 2'd1;
  localparam lane_t LANE_C = 2'd2;
  localparam lane_t LANE_D = 2'd3;

  // One-hot decode of a lane select.
  function automatic logic [NUM_LANES-1:0] lane_decode(input lane_t sel);
    lane_decode      = '0;
    lane_decode[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Single-lane FIFO: pointers wrap modulo DEPTH, occupancy tracked by a separate count.
module lane_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic             full_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & (count_q != '0);

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Pointer, count and full-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage array; contents are don't-care while the lane is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign full       = full_q;
  assign count      = count_q;

endmodule

// File: rtl/demux_route4.sv
// 1-to-4 stream distributor: routes each accepted word into one of four lane FIFOs.
module demux_route4
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           in_data,
  input  lane_t                      in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [NUM_LANES-1:0]       lane_full,
  output logic                       busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [NUM_LANES-1:0] sel_dec;
  logic [NUM_LANES-1:0] push_lane;
  logic [NUM_LANES-1:0] lane_nonempty;
  logic [CW-1:0]        lane_count [NUM_LANES];

  // Ready only looks at registered full flags, never at out_ready.
  assign in_ready  = ~rst & en & ~lane_full[in_sel];
  assign sel_dec   = lane_decode(in_sel);
  assign push_lane = sel_dec & {NUM_LANES{in_valid & in_ready}};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_lane[k]),
      .push_data  (in_data),
      .pop        (out_ready[k]),
      .head_data  (out_data[k*WIDTH +: WIDTH]),
      .head_valid (out_valid[k]),
      .full       (lane_full[k]),
      .count      (lane_count[k])
    );
    assign lane_nonempty[k] = (lane_count[k] != '0);
  end

  assign busy = |lane_nonempty;

endmodule

// File: tb/tb_demux_route4.sv
// Scoreboard bench for demux_route4: per-lane queues model the expected contents.
module tb_demux_route4;
  import demux_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [3:0]   in_data;
  lane_t        in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [3:0]   lane_full;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [3:0] model_q [4][$];

  demux_route4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_full (lane_full),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the queues, then apply this cycle's handshakes.
  always @(negedge clk) begin
    logic exp_rdy;
    logic [3:0] exp_slice;
    logic any;
    if (rst) for (int k = 0; k < 4; k++) model_q[k].delete();
    any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_slice = (model_q[k].size() != 0) ? model_q[k][0] : 4'h0;
      check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(model_q[k].size() != 0));
      check($sformatf("out_data[%0d]", k), 32'(out_data[k*4 +: 4]), 32'(exp_slice));
      check($sformatf("lane_full[%0d]", k), 32'(lane_full[k]), 32'(model_q[k].size() == DEPTH));
      if (model_q[k].size() != 0) any = 1'b1;
    end
    check("busy", 32'(busy), 32'(any));
    exp_rdy = !rst && en && (model_q[in_sel].size() < DEPTH);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (!rst) begin
      for (int k = 0; k < 4; k++)
        if (model_q[k].size() != 0 && out_ready[k]) void'(model_q[k].pop_front());
      if (in_valid && exp_rdy) model_q[in_sel].push_back(in_data);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until accepted, bounded by a cycle budget.
  task automatic send(input logic [3:0] d, input lane_t s, input int budget);
    logic acc;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      next_cycle();
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=not_accepted exp=accepted data=%0h sel=%0d t=%0t", d, s, $time);
    end
  endtask

  task automatic expect_blocked(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("in_ready_blocked", 32'(in_ready), 32'(0));
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_data = 4'h0; in_sel = LANE_A; in_valid = 1'b0; out_ready = 4'h0;
    repeat (3) next_cycle();
    rst = 1'b0;
    next_cycle();

    // Routing to each lane on consecutive cycles.
    en = 1'b1; out_ready = 4'hF;
    send(4'h3, LANE_A, 5);
    send(4'h5, LANE_B, 5);
    send(4'hA, LANE_C, 5);
    send(4'hC, LANE_D, 5);
    repeat (3) next_cycle();

    // Backpressure on lane B.
    out_ready = 4'b1101;
    send(4'h1, LANE_B, 5);
    send(4'h2, LANE_B, 5);
    @(negedge clk);
    check("lane_full_b", 32'(lane_full[1]), 32'(1));
    next_cycle();
    in_data = 4'h3; in_sel = LANE_B; in_valid = 1'b1;
    expect_blocked(2);
    out_ready = 4'hF;
    send(4'h3, LANE_B, 10);
    repeat (4) next_cycle();

    // Head-of-line blocking behind a full lane C.
    out_ready = 4'b1011;
    send(4'h1, LANE_C, 5);
    send(4'h2, LANE_C, 5);
    in_data = 4'h7; in_sel = LANE_C; in_valid = 1'b1;
    expect_blocked(3);
    out_ready = 4'hF;
    send(4'h7, LANE_C, 10);
    repeat (4) next_cycle();

    // Simultaneous push and pop on lane D.
    out_ready = 4'b0111;
    send(4'h4, LANE_D, 5);
    out_ready = 4'hF;
    send(4'hE, LANE_D, 5);
    @(negedge clk);
    check("simul_d_valid", 32'(out_valid[3]), 32'(1));
    check("simul_d_data", 32'(out_data[15:12]), 32'(4'hE));
    repeat (3) next_cycle();

    // Enable low stalls the producer while lane B drains.
    out_ready = 4'b1101;
    send(4'h6, LANE_B, 5);
    send(4'h8, LANE_B, 5);
    out_ready = 4'hF; en = 1'b0;
    in_data = 4'h9; in_sel = LANE_A; in_valid = 1'b1;
    expect_blocked(3);
    en = 1'b1;
    @(negedge clk);
    check("en_accept", 32'(in_ready), 32'(1));
    next_cycle();
    in_valid = 1'b0;
    repeat (3) next_cycle();

    // Asynchronous reset with lanes A and C holding two words.
    out_ready = 4'b1010;
    send(4'h1, LANE_A, 5);
    send(4'h2, LANE_A, 5);
    send(4'h3, LANE_C, 5);
    send(4'h4, LANE_C, 5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) model_q[k].delete();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_lane_full", 32'(lane_full), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    next_cycle();
    out_ready = 4'hF;
    send(4'hF, LANE_A, 5);
    repeat (3) next_cycle();

    // Randomized traffic; producer holds each word until accepted.
    begin
      logic acc;
      acc = 1'b0;
      repeat (400) begin
        next_cycle();
        if (acc) begin
          in_valid = 1'b0;
          acc = 1'b0;
        end
        if (!in_valid && $urandom_range(0, 3) != 0) begin
          in_data  = 4'($urandom);
          in_sel   = lane_t'($urandom);
          in_valid = 1'b1;
        end
        en        = ($urandom_range(0, 7) != 0);
        out_ready = 4'($urandom);
        @(negedge clk);
        if (in_valid && in_ready) acc = 1'b1;
      end
      next_cycle();
      if (acc) in_valid = 1'b0;
    end

    // Drain everything.
    in_valid = 1'b0; en = 1'b0; out_ready = 4'hF;
    repeat (5) next_cycle();
    @(negedge clk);
    check("final_busy", 32'(busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
